// File: rtl/static_bus_initiator_pkg.sv
// Shared definitions for the static expansion bus initiator.
// - Region codes driven onto CX_A[23:20] (what the address decoder answers to).
// - FSM state encoding used by the top level.
package static_bus_initiator_pkg;

  localparam logic [3:0] USB        = 4'h0;
  localparam logic [3:0] SRAM_1     = 4'h1;
  localparam logic [3:0] SRAM_2     = 4'h2;
  localparam logic [3:0] SEG        = 4'h3;
  localparam logic [3:0] DIPSW      = 4'h4;
  localparam logic [3:0] KEYPAD_A   = 4'h5;
  localparam logic [3:0] KEYPAD_B   = 4'h6;
  localparam logic [3:0] LED_T      = 4'h7;
  localparam logic [3:0] LCD        = 4'h8;
  localparam logic [3:0] DOT_D      = 4'h9;
  localparam logic [3:0] DOT_C      = 4'hA;
  localparam logic [3:0] STEP_MOTOR = 4'hB;
  localparam logic [3:0] USER_CS1   = 4'hC;
  localparam logic [3:0] USER_CS2   = 4'hD;
  localparam logic [3:0] USER_CS3   = 4'hE;
  localparam logic [3:0] USER_CS4   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_TURN
  } bus_state_e;

endpackage

// File: rtl/static_bus_initiator_phase_timer.sv
// bus_phase_timer: loadable 4-bit down-counter timing one bus phase.
// Ports:
//   CLK, nRESET  - clock, async active-low reset
//   load_i       - load load_val_i on this edge (phase entry)
//   load_val_i   - phase length in cycles (1..15)
//   tc_o         - terminal count: high during the last cycle of the phase
module bus_phase_timer (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       tc_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 4'd0) begin
      // Runs down to 0 and parks there while the FSM is idle.
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign tc_o = (cnt_q == 4'd1);

endmodule

// File: rtl/static_bus_initiator.sv
// static_bus_initiator: master end of the static expansion bus protocol.
// Accepts one request at a time and runs a timed SETUP/STROBE/HOLD/TURN
// cycle on the chip-select/strobe bus.
// Ports:
//   CLK, nRESET            - clock, async active-low reset
//   REQ, REQ_WR            - request, direction (1 = write)
//   REQ_ADDR, REQ_WDATA    - region code, write data
//   REQ_ACK                - one-cycle completion pulse (first TURN cycle)
//   RDATA                  - captured read data
//   BUSY                   - cycle or turnaround in progress
//   CX_A, nPX_CS5          - bus address [23:20], chip select (active low)
//   nPX_PWE, nPX_POE       - write / read strobes (active low)
//   CX_D                   - bidirectional data, driven only on writes
module static_bus_initiator
  import static_bus_initiator_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned TURN_CYC   = 1
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        REQ,
  input  logic        REQ_WR,
  input  logic [3:0]  REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  output logic        REQ_ACK,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic [3:0]  CX_A,
  output logic        nPX_CS5,
  output logic        nPX_PWE,
  output logic        nPX_POE,
  inout  wire  [15:0] CX_D
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYC);

  bus_state_e  state_q;
  logic        wr_q;
  logic [3:0]  addr_q;
  logic [15:0] dout_q;
  logic        oe_q;
  logic        cs_n_q;
  logic        pwe_n_q;
  logic        poe_n_q;
  logic        ack_q;
  logic        busy_q;
  logic [15:0] rdata_q;

  logic        tmr_load_d;
  logic [3:0]  tmr_val_d;
  logic        tmr_tc;

  bus_phase_timer u_timer (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .load_i     (tmr_load_d),
    .load_val_i (tmr_val_d),
    .tc_o       (tmr_tc)
  );

  // Reload the timer on every edge that enters a new phase.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = SETUP_LD;
    unique case (state_q)
      ST_IDLE:   if (REQ)    begin tmr_load_d = 1'b1; tmr_val_d = SETUP_LD;  end
      ST_SETUP:  if (tmr_tc) begin tmr_load_d = 1'b1; tmr_val_d = STROBE_LD; end
      ST_STROBE: if (tmr_tc) begin tmr_load_d = 1'b1; tmr_val_d = HOLD_LD;   end
      ST_HOLD:   if (tmr_tc) begin tmr_load_d = 1'b1; tmr_val_d = TURN_LD;   end
      default:   ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 4'h0;
      dout_q  <= 16'h0000;
      oe_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      pwe_n_q <= 1'b1;
      poe_n_q <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (REQ) begin
            wr_q    <= REQ_WR;
            addr_q  <= REQ_ADDR;
            dout_q  <= REQ_WDATA;
            oe_q    <= REQ_WR;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_tc) begin
            pwe_n_q <= ~wr_q;
            poe_n_q <= wr_q;
            state_q <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (tmr_tc) begin
            pwe_n_q <= 1'b1;
            poe_n_q <= 1'b1;
            // Responder is still driving here; capture before POE rises.
            if (!wr_q) rdata_q <= CX_D;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_tc) begin
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ST_TURN;
          end
        end
        ST_TURN: begin
          if (tmr_tc) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CX_D    = oe_q ? dout_q : 16'hzzzz;
  assign CX_A    = addr_q;
  assign nPX_CS5 = cs_n_q;
  assign nPX_PWE = pwe_n_q;
  assign nPX_POE = poe_n_q;
  assign REQ_ACK = ack_q;
  assign BUSY    = busy_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_static_bus_initiator.sv
module tb_static_bus_initiator;
  import static_bus_initiator_pkg::*;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  always #5 CLK = ~CLK;

  // default-parameter instance
  logic        REQ = 1'b0, REQ_WR = 1'b0;
  logic [3:0]  REQ_ADDR = 4'h0;
  logic [15:0] REQ_WDATA = 16'h0;
  logic        REQ_ACK, BUSY, nPX_CS5, nPX_PWE, nPX_POE;
  logic [15:0] RDATA;
  logic [3:0]  CX_A;
  wire  [15:0] CX_D;

  static_bus_initiator dut (
    .CLK(CLK), .nRESET(nRESET), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_ACK(REQ_ACK), .RDATA(RDATA), .BUSY(BUSY),
    .CX_A(CX_A), .nPX_CS5(nPX_CS5), .nPX_PWE(nPX_PWE), .nPX_POE(nPX_POE), .CX_D(CX_D)
  );

  // fast instance, all phases one cycle
  logic        f_req = 1'b0, f_wr = 1'b0;
  logic [3:0]  f_addr = 4'h0;
  logic [15:0] f_wdata = 16'h0;
  logic        f_ack, f_busy, f_cs, f_pwe, f_poe;
  logic [15:0] f_rdata;
  logic [3:0]  f_a;
  wire  [15:0] f_d;

  static_bus_initiator #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(1)) dut_f (
    .CLK(CLK), .nRESET(nRESET), .REQ(f_req), .REQ_WR(f_wr), .REQ_ADDR(f_addr),
    .REQ_WDATA(f_wdata), .REQ_ACK(f_ack), .RDATA(f_rdata), .BUSY(f_busy),
    .CX_A(f_a), .nPX_CS5(f_cs), .nPX_PWE(f_pwe), .nPX_POE(f_poe), .CX_D(f_d)
  );

  // ---------------- decoder / peripheral model ----------------
  logic [7:0]  dip = 8'h00;
  logic [3:0]  push = 4'hF;
  logic [7:0]  seg_data = 8'h00, led = 8'h00, led_f = 8'h00;
  logic [5:0]  seg_com = 6'h00;
  logic        mdl_oe;
  logic [15:0] mdl_d;

  // keypad keys are active low: a pressed key reads back as 1
  always_comb begin
    mdl_oe = !nPX_CS5 && !nPX_POE;
    case (CX_A)
      DIPSW:    mdl_d = {8'h00, dip};
      KEYPAD_B: mdl_d = {12'h000, ~push};
      default:  mdl_d = 16'h0000;
    endcase
  end
  assign CX_D = mdl_oe ? mdl_d : 16'hzzzz;

  always @(posedge nPX_PWE) begin
    if (!nPX_CS5) begin
      if (CX_A == SEG) begin
        seg_data = CX_D[7:0];
        seg_com  = CX_D[13:8];
      end else if (CX_A == LED_T) begin
        led = CX_D[7:0];
      end
    end
  end

  always @(posedge f_pwe) if (!f_cs && f_a == LED_T) led_f = f_d[7:0];

  // ---------------- monitors ----------------
  int unsigned cyc = 0, ack_cnt = 0, acc_cnt = 0, cs_fall = 0, viol = 0;
  int unsigned f_acc_n = 0, f_hi_run = 0, f_gap = 0;
  int unsigned f_acc_cyc [2];
  logic        cs_prev = 1'b1, f_low_seen = 1'b0, rd_active = 1'b0;

  function automatic logic floating(input logic [15:0] d);
    return $isunknown(d) ? 1'b1 : (d == 16'h0000);
  endfunction

  always @(posedge CLK) begin
    cyc++;
    if (REQ_ACK) ack_cnt++;
    if (nRESET && REQ && !BUSY) acc_cnt++;
    if (nRESET && f_req && !f_busy) begin
      if (f_acc_n < 2) f_acc_cyc[f_acc_n] = cyc;
      f_acc_n++;
    end
  end

  always @(negedge CLK) begin
    if (!nPX_CS5 && cs_prev) cs_fall++;
    cs_prev = nPX_CS5;
    if (nPX_CS5 && (!nPX_PWE || !nPX_POE)) viol++;
    if (f_cs && (!f_pwe || !f_poe)) viol++;
    if (rd_active && !nPX_PWE) viol++;
    if (rd_active && nPX_POE && !floating(CX_D)) viol++;
    if (f_cs) f_hi_run++;
    else begin
      if (f_low_seen && f_hi_run != 0) f_gap = f_hi_run;
      f_low_seen = 1'b1;
      f_hi_run   = 0;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!BUSY) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle_timeout: BUSY still 1 after 40 cycles, expected 0", nm);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  dip;
    logic [3:0]  push;
    logic [15:0] exp_rdata;
    logic [7:0]  exp_seg_data;
    logic [5:0]  exp_seg_com;
    logic [7:0]  exp_led;
  } vec_t;

  logic [15:0] last_rd = 16'h0000;

  task automatic do_access(input vec_t v, input string nm);
    int lat = 0, sb = 0;
    int unsigned v0;
    wait_idle(nm);
    v0 = viol;
    dip = v.dip; push = v.push; rd_active = !v.wr;
    REQ = 1'b1; REQ_WR = v.wr; REQ_ADDR = v.addr; REQ_WDATA = v.wdata;
    @(posedge CLK); #1;
    REQ = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 1) begin
        chk({nm, "_setup_cs"}, 32'(nPX_CS5), 32'h0);
        chk({nm, "_setup_addr"}, 32'(CX_A), 32'(v.addr));
      end
      if (sb == 0 && (!nPX_PWE || !nPX_POE)) sb = i;
      if (REQ_ACK) begin
        lat = i;
        chk({nm, "_turn_undriven"}, 32'(floating(CX_D)), 32'h1);
        chk({nm, "_turn_cs"}, 32'(nPX_CS5), 32'h1);
        if (!v.wr) chk({nm, "_rdata"}, 32'(RDATA), 32'(v.exp_rdata));
        break;
      end
      @(posedge CLK); #1;
    end
    rd_active = 1'b0;
    chk({nm, "_ack_latency"}, 32'(lat), 32'd9);
    chk({nm, "_strobe_start"}, 32'(sb), 32'd3);
    chk({nm, "_protocol"}, 32'(viol - v0), 32'h0);
    if (v.wr) begin
      chk({nm, "_rdata_kept"}, 32'(RDATA), 32'(last_rd));
      if (v.addr == SEG) begin
        chk({nm, "_seg_data"}, 32'(seg_data), 32'(v.exp_seg_data));
        chk({nm, "_seg_com"}, 32'(seg_com), 32'(v.exp_seg_com));
      end else if (v.addr == LED_T) begin
        chk({nm, "_led"}, 32'(led), 32'(v.exp_led));
      end
    end else begin
      last_rd = v.exp_rdata;
    end
  endtask

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned a0, k0, c0;
    bit ok;
    vec_t pr;

    vecs[0] = '{wr:1'b1, addr:SEG,      wdata:16'h3F06, dip:8'h00, push:4'hF, exp_rdata:16'h0000, exp_seg_data:8'h06, exp_seg_com:6'h3F, exp_led:8'h00};
    vecs[1] = '{wr:1'b0, addr:DIPSW,    wdata:16'hDEAD, dip:8'hA5, push:4'hF, exp_rdata:16'h00A5, exp_seg_data:8'h00, exp_seg_com:6'h00, exp_led:8'h00};
    vecs[2] = '{wr:1'b0, addr:KEYPAD_B, wdata:16'hBEEF, dip:8'h00, push:4'b1010, exp_rdata:16'h0005, exp_seg_data:8'h00, exp_seg_com:6'h00, exp_led:8'h00};
    vecs[3] = '{wr:1'b1, addr:LED_T,    wdata:16'h00C3, dip:8'h00, push:4'hF, exp_rdata:16'h0000, exp_seg_data:8'h00, exp_seg_com:6'h00, exp_led:8'hC3};
    vecs[4] = '{wr:1'b0, addr:DIPSW,    wdata:16'hFFFF, dip:8'h3C, push:4'hF, exp_rdata:16'h003C, exp_seg_data:8'h00, exp_seg_com:6'h00, exp_led:8'h00};
    vecs[5] = '{wr:1'b1, addr:SEG,      wdata:16'h2A5B, dip:8'h00, push:4'hF, exp_rdata:16'h0000, exp_seg_data:8'h5B, exp_seg_com:6'h2A, exp_led:8'h00};
    vecs[6] = '{wr:1'b0, addr:KEYPAD_B, wdata:16'h1234, dip:8'h00, push:4'b0011, exp_rdata:16'h000C, exp_seg_data:8'h00, exp_seg_com:6'h00, exp_led:8'h00};

    // reset state
    #23;
    chk("rst_cs",    32'(nPX_CS5), 32'h1);
    chk("rst_pwe",   32'(nPX_PWE), 32'h1);
    chk("rst_poe",   32'(nPX_POE), 32'h1);
    chk("rst_addr",  32'(CX_A), 32'h0);
    chk("rst_ack",   32'(REQ_ACK), 32'h0);
    chk("rst_busy",  32'(BUSY), 32'h0);
    chk("rst_rdata", 32'(RDATA), 32'h0);
    chk("rst_data_undriven", 32'(floating(CX_D)), 32'h1);
    @(negedge CLK); nRESET = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 7; i++) do_access(vecs[i], $sformatf("vec%0d", i));

    // REQ held high through an active write: one cycle, next accept when BUSY first reads 0
    wait_idle("spam");
    a0 = acc_cnt; k0 = ack_cnt; c0 = cs_fall;
    REQ = 1'b1; REQ_WR = 1'b1; REQ_ADDR = SEG; REQ_WDATA = 16'h1234;
    @(posedge CLK); #1;
    chk("spam_first_accept", acc_cnt - a0, 32'd1);
    repeat (9) @(posedge CLK);
    #1;
    chk("spam_no_queue", acc_cnt - a0, 32'd1);
    chk("spam_one_ack", ack_cnt - k0, 32'd1);
    chk("spam_one_cs", cs_fall - c0, 32'd1);
    chk("spam_busy_low", 32'(BUSY), 32'h0);
    @(posedge CLK); #1;
    chk("spam_second_accept", acc_cnt - a0, 32'd2);
    chk("spam_busy_again", 32'(BUSY), 32'h1);
    REQ = 1'b0;
    wait_idle("spam_end");
    chk("spam_seg_data", 32'(seg_data), 32'h34);
    chk("spam_seg_com", 32'(seg_com), 32'h12);

    // fast instance: back-to-back writes to LED_T
    @(negedge CLK);
    f_req = 1'b1; f_wr = 1'b1; f_addr = LED_T; f_wdata = 16'h0001;
    @(posedge CLK); #1;
    f_wdata = 16'h0080;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (f_acc_n >= 2) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    f_req = 1'b0;
    chk("fast_second_accept_seen", 32'(ok), 32'h1);
    repeat (8) @(negedge CLK);
    chk("fast_busy_idle", 32'(f_busy), 32'h0);
    chk("fast_accepts", f_acc_n, 32'd2);
    chk("fast_spacing", f_acc_cyc[1] - f_acc_cyc[0], 32'd5);
    chk("fast_led", 32'(led_f), 32'h80);
    chk("fast_cs_gap", f_gap, 32'd2);

    // reset during STROBE of a write
    wait_idle("rst_mid");
    REQ = 1'b1; REQ_WR = 1'b1; REQ_ADDR = USER_CS1; REQ_WDATA = 16'hA5A5;
    @(posedge CLK); #1;
    REQ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_mid_in_strobe", 32'(nPX_PWE), 32'h0);
    k0 = ack_cnt;
    #2 nRESET = 1'b0;
    #1;
    chk("rst_mid_cs", 32'(nPX_CS5), 32'h1);
    chk("rst_mid_pwe", 32'(nPX_PWE), 32'h1);
    chk("rst_mid_poe", 32'(nPX_POE), 32'h1);
    chk("rst_mid_undriven", 32'(floating(CX_D)), 32'h1);
    chk("rst_mid_busy", 32'(BUSY), 32'h0);
    chk("rst_mid_rdata", 32'(RDATA), 32'h0);
    repeat (2) @(negedge CLK);
    nRESET = 1'b1;
    last_rd = 16'h0000;
    repeat (12) @(posedge CLK);
    #1;
    chk("rst_mid_no_ack", ack_cnt - k0, 32'd0);
    pr = '{wr:1'b1, addr:LED_T, wdata:16'h0055, dip:8'h00, push:4'hF, exp_rdata:16'h0000, exp_seg_data:8'h00, exp_seg_com:6'h00, exp_led:8'h55};
    do_access(pr, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
